// File: rtl/am_insertion_top.sv
// am_insertion_top: periodic per-lane alignment-marker inserter with BIP3/BIP7 parity and ready/valid stall.
module am_insertion_top #(
    parameter int N_LANES = 20,
    parameter int NB_DATA = 66,
    parameter int AM_PERIOD = 16384,
    parameter int NB_AM_COUNT = $clog2(AM_PERIOD),
    parameter int NB_DATA_BUS = NB_DATA * N_LANES,
    parameter logic [24*N_LANES-1:0] AM_ENCODINGS = {
        24'hC16821, 24'h9D718E, 24'h594BE8, 24'h4D957B, 24'hF50709,
        24'hDD14C2, 24'h9A4A26, 24'h7B4566, 24'hA02476, 24'h68C9FB,
        24'hFD6C99, 24'hB99155, 24'h5CB9B2, 24'h1AF8BD, 24'h83C7CA,
        24'h3536CD, 24'hC4314C, 24'hADD6B7, 24'h5F662A, 24'hC0F0E5
    }
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_enable,
    input  logic                   i_valid,
    input  logic [NB_DATA_BUS-1:0] i_data,
    output logic                   o_ready,
    output logic                   o_valid,
    output logic [NB_DATA_BUS-1:0] o_data,
    output logic                   o_am_inserted
);
    logic [NB_AM_COUNT-1:0]      am_count;
    logic [N_LANES-1:0][7:0]     bip_acc;
    logic [N_LANES-1:0][7:0]     bip_next;
    logic [NB_DATA_BUS-1:0]      am_bus;
    logic                        am_slot;

    function automatic logic [7:0] bip_of(input logic [NB_DATA-1:0] blk);
        bip_of = '0;
        for (int k = 0; k < NB_DATA; k++)
            bip_of[3'(k < 2 ? k + 3 : k - 2)] ^= blk[NB_DATA-1-k];
    endfunction

    assign am_slot = am_count == '0;
    assign o_ready = i_enable & ~am_slot;

    for (genvar j = 0; j < N_LANES; j++) begin : g_lane
        localparam int HI = NB_DATA_BUS - j * NB_DATA - 1;
        logic [23:0] m;
        assign m = AM_ENCODINGS[24*(N_LANES-j)-1 -: 24];
        assign am_bus[HI -: NB_DATA] = {2'b01, m, bip_acc[j], ~m, ~bip_acc[j]};
        assign bip_next[j] = am_slot ? bip_of(am_bus[HI -: NB_DATA])
                                     : bip_acc[j] ^ bip_of(i_data[HI -: NB_DATA]);
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            am_count      <= '0;
            bip_acc       <= '0;
            o_valid       <= 1'b0;
            o_am_inserted <= 1'b0;
            o_data        <= '0;
        end else if (!i_enable) begin
            o_valid <= 1'b0;
        end else if (!i_valid) begin
            o_valid       <= 1'b0;
            o_am_inserted <= 1'b0;
        end else begin
            o_valid       <= 1'b1;
            o_am_inserted <= am_slot;
            o_data        <= am_slot ? am_bus : i_data;
            bip_acc       <= bip_next;
            am_count      <= am_count == NB_AM_COUNT'(AM_PERIOD - 1) ? '0 : am_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_am_insertion_top.sv
// tb_am_insertion_top: directed checks on a short-period instance plus a scoreboard run on the default instance.
module tb_am_insertion_top;
    localparam int NB = 66;
    localparam int NL = 20;
    localparam int W = NB * NL;
    localparam int PD = 16384;
    localparam logic [23:0] TBL [NL] = '{
        24'hC16821, 24'h9D718E, 24'h594BE8, 24'h4D957B, 24'hF50709,
        24'hDD14C2, 24'h9A4A26, 24'h7B4566, 24'hA02476, 24'h68C9FB,
        24'hFD6C99, 24'hB99155, 24'h5CB9B2, 24'h1AF8BD, 24'h83C7CA,
        24'h3536CD, 24'hC4314C, 24'hADD6B7, 24'h5F662A, 24'hC0F0E5
    };

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst4, en4, v4, r4, ov4, ai4;
    logic [W-1:0] d4, od4;
    logic rstd, end_, vd, rd, ovd, aid;
    logic [W-1:0] dd, odd;

    am_insertion_top #(.AM_PERIOD(4)) dut4 (
        .i_clock(clk), .i_reset(rst4), .i_enable(en4), .i_valid(v4), .i_data(d4),
        .o_ready(r4), .o_valid(ov4), .o_data(od4), .o_am_inserted(ai4)
    );

    am_insertion_top dutd (
        .i_clock(clk), .i_reset(rstd), .i_enable(end_), .i_valid(vd), .i_data(dd),
        .o_ready(rd), .o_valid(ovd), .o_data(odd), .o_am_inserted(aid)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [65:0] lane(input logic [W-1:0] bus, input int j);
        return bus[W-1-j*NB -: NB];
    endfunction

    function automatic logic [65:0] am_blk(input logic [23:0] m, input logic [7:0] b);
        return {2'b01, m, b, ~m, ~b};
    endfunction

    // Byte-wise XOR gives the interleaved parity MSB-first; the sync header folds into bits 3 and 4.
    function automatic logic [7:0] tb_bip(input logic [65:0] b);
        logic [7:0] x, r;
        x = '0;
        for (int n = 0; n < 8; n++) x ^= b[63-8*n -: 8];
        for (int i = 0; i < 8; i++) r[i] = x[7-i];
        r[3] ^= b[65];
        r[4] ^= b[64];
        return r;
    endfunction

    function automatic logic [W-1:0] rnd();
        logic [1343:0] t;
        for (int i = 0; i < 42; i++) t[i*32 +: 32] = $urandom;
        return t[W-1:0];
    endfunction

    logic pat [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic flg [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic rdy [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [W-1:0] exp_bus, sent;
    logic [W-1:0] q [$];
    logic [7:0] mb [NL];
    logic acc;
    int am_seen, blk_since, total, dl;

    initial begin
        rst4 = 1'b0; en4 = 1'b1; v4 = 1'b1; d4 = '0;
        rstd = 1'b0; end_ = 1'b1; vd = 1'b0; dd = '0;
        #1;
        check("rst_ready", r4, 0);
        check("rst_valid", ov4, 0);
        check("rst_data", lane(od4, 0), 0);
        #1 rst4 = 1'b1;
        #1 check("first_ready", r4, 0);
        tick;
        check("am1_valid", ov4, 1);
        check("am1_flag", ai4, 1);
        check("am1_lane0", lane(od4, 0), {2'b01, 24'hC16821, 8'h00, 24'h3E97DE, 8'hFF});
        check("am1_lane19", lane(od4, 19), {2'b01, 24'hC0F0E5, 8'h00, 24'h3F0F1A, 8'hFF});
        check("am1_ready", r4, 1);
        for (int n = 2; n <= 4; n++) begin
            tick;
            check("d_valid", ov4, 1);
            check("d_flag", ai4, 0);
            check("d_ready", r4, n != 4);
        end
        tick;
        check("am2_flag", ai4, 1);
        check("am2_lane0", lane(od4, 0), {2'b01, 24'hC16821, 8'h10, 24'h3E97DE, 8'hEF});
        d4[W-3] = 1'b1;
        tick;
        check("flip_data", lane(od4, 0), 66'h0_8000_0000_0000_0000);
        d4 = '0;
        tick; tick; tick;
        check("am3_flag", ai4, 1);
        check("am3_lane0", lane(od4, 0), {2'b01, 24'hC16821, 8'h11, 24'h3E97DE, 8'hEE});
        check("am3_lane19", lane(od4, 19), {2'b01, 24'hC0F0E5, 8'h10, 24'h3F0F1A, 8'hEF});
        for (int i = 0; i < 6; i++) begin
            v4 = pat[i];
            tick;
            check("gap_valid", ov4, pat[i]);
            check("gap_flag", ai4, flg[i]);
            check("gap_ready", r4, rdy[i]);
        end
        v4 = 1'b1;
        check("gap_am_lane0", lane(od4, 0), {2'b01, 24'hC16821, 8'h10, 24'h3E97DE, 8'hEF});
        tick;
        check("pre_freeze_flag", ai4, 0);
        en4 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick;
            check("frz_valid", ov4, 0);
            check("frz_ready", r4, 0);
        end
        en4 = 1'b1;
        tick;
        check("thaw1_flag", ai4, 0);
        check("thaw1_ready", r4, 1);
        tick;
        check("thaw2_flag", ai4, 0);
        check("thaw2_ready", r4, 0);
        tick;
        check("thaw_am_flag", ai4, 1);
        check("thaw_am_valid", ov4, 1);
        d4 = {NL{66'h2_AAAA_5555_AAAA_5555}};
        tick;
        check("pre_rst_ready", r4, 1);
        check("pre_rst_data", lane(od4, 0), 66'h2_AAAA_5555_AAAA_5555);
        rst4 = 1'b0;
        #1;
        check("mid_rst_valid", ov4, 0);
        check("mid_rst_data", lane(od4, 0), 0);
        check("mid_rst_ready", r4, 0);
        tick;
        rst4 = 1'b1;
        #1 check("post_rst_ready", r4, 0);
        tick;
        check("post_rst_flag", ai4, 1);
        check("post_rst_am", lane(od4, 0), {2'b01, 24'hC16821, 8'h00, 24'h3E97DE, 8'hFF});
        tick;
        check("post_rst_data", lane(od4, 0), 66'h2_AAAA_5555_AAAA_5555);

        rstd = 1'b1; vd = 1'b1; dd = rnd();
        am_seen = 0; blk_since = 0; total = 0;
        for (int j = 0; j < NL; j++) mb[j] = '0;
        for (int c = 0; c < 3 * PD + 1; c++) begin
            acc = rd;
            if (acc) q.push_back(dd);
            tick;
            check("sb_valid", ovd, 1);
            if (aid) begin
                if (am_seen > 0) check("sb_blocks_per_am", blk_since, PD - 1);
                for (int j = 0; j < NL; j++) begin
                    check($sformatf("sb_am_lane%0d", j), lane(odd, j), am_blk(TBL[j], mb[j]));
                    mb[j] = tb_bip(am_blk(TBL[j], mb[j]));
                end
                am_seen++;
                blk_since = 0;
            end else begin
                check("sb_queue_nonempty", q.size() != 0, 1);
                exp_bus = q.size() != 0 ? q.pop_front() : '0;
                dl = 0;
                for (int j = NL - 1; j >= 0; j--) if (lane(odd, j) !== lane(exp_bus, j)) dl = j;
                n_cmp++;
                assert (odd === exp_bus) else begin
                    n_err++;
                    $error("FAIL sb_data lane %0d: observed %h expected %h", dl, lane(odd, dl), lane(exp_bus, dl));
                end
                for (int j = 0; j < NL; j++) mb[j] ^= tb_bip(lane(exp_bus, j));
                blk_since++;
                total++;
            end
            if (acc) dd = rnd();
        end
        check("sb_am_count", am_seen, 4);
        check("sb_total_data", total, 3 * (PD - 1));
        check("sb_queue_empty", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
